// File: rtl/blockram_pkg.sv
// Shared definitions for the multi-way init block RAM: controller states,
// byte-lane granule and a ceiling-log2 helper for sizing set pointers.
package blockram_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } blockram_state_e;

    localparam int unsigned BYTE_GRANULE = 8;

    function automatic int unsigned blockram_clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/byte_enable_blockram_way.sv
// One way of the block RAM: a single-port array with byte-lane write enables.
// Read data is combinational; WRITE_FIRST selects pre-write or merged data.
module byte_enable_blockram_way
    import blockram_pkg::*;
#(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 32,
    parameter int NUMBER_SETS                 = 64,
    parameter int SET_PTR_WIDTH_IN_BITS       = 6,
    parameter int WRITE_FIRST                 = 0
) (
    input  logic                                     clk_in,
    input  logic                                     en,
    input  logic                                     we,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS/8-1:0] byte_en,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]         set_addr,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]   write_element,
    output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]   read_element
);

    localparam int LANES = SINGLE_ELEMENT_SIZE_IN_BITS / BYTE_GRANULE;

    logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] mem [NUMBER_SETS];
    logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] stored;
    logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] merged;

    assign stored = mem[set_addr];

    // Disabled lanes keep the stored byte, so a write stores the full merged word.
    always_comb begin
        merged = stored;
        for (int b = 0; b < LANES; b++) begin
            if (we && byte_en[b]) begin
                merged[b*BYTE_GRANULE +: BYTE_GRANULE] = write_element[b*BYTE_GRANULE +: BYTE_GRANULE];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (en && we) begin
            mem[set_addr] <= merged;
        end
    end

    assign read_element = (WRITE_FIRST != 0) ? merged : stored;

endmodule

// File: rtl/multi_way_init_blockram.sv
// Multi-way block RAM that sweeps INIT_VALUE into every set after reset or on
// request. Define BLOCKRAM_OUTPUT_REG_EN for an extra output stage (latency 2).
module multi_way_init_blockram
    import blockram_pkg::*;
#(
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 32,
    parameter int NUMBER_SETS                 = 64,
    parameter int SET_PTR_WIDTH_IN_BITS       = 6,
    parameter int NUMBER_WAYS                 = 4,
    parameter int WRITE_FIRST                 = 0,
    parameter logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] INIT_VALUE = '0
) (
    input  logic                                                 clk_in,
    input  logic                                                 reset_in,
    input  logic                                                 init_req_in,
    input  logic                                                 access_en_in,
    input  logic [NUMBER_WAYS-1:0]                               write_en_in,
    input  logic [SINGLE_ELEMENT_SIZE_IN_BITS/8-1:0]             byte_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]                     access_set_addr_in,
    input  logic [NUMBER_WAYS*SINGLE_ELEMENT_SIZE_IN_BITS-1:0]   write_element_in,
    output logic [NUMBER_WAYS*SINGLE_ELEMENT_SIZE_IN_BITS-1:0]   read_element_out,
    output logic                                                 read_valid_out,
    output logic                                                 ready_out
);

    localparam int EW = SINGLE_ELEMENT_SIZE_IN_BITS;
    localparam int DW = NUMBER_WAYS * EW;
    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUMBER_SETS - 1);

    blockram_state_e                  state_q, state_d;
    logic [SET_PTR_WIDTH_IN_BITS-1:0] count_q, count_d;
    logic                             accept;
    logic                             sweeping;
    logic [DW-1:0]                    rd_raw;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= INIT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // An init request in READY wins over any access presented in the same cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        accept  = 1'b0;
        case (state_q)
            INIT: begin
                count_d = count_q + 1'b1;
                if (count_q == LAST_SET) begin
                    state_d = READY;
                    count_d = '0;
                end
            end
            READY: begin
                if (init_req_in) begin
                    state_d = INIT;
                    count_d = '0;
                end else begin
                    accept = access_en_in;
                end
            end
            default: begin
                state_d = INIT;
                count_d = '0;
            end
        endcase
    end

    assign sweeping  = (state_q == INIT);
    assign ready_out = (state_q == READY);

    for (genvar w = 0; w < NUMBER_WAYS; w++) begin : g_way
        byte_enable_blockram_way #(
            .SINGLE_ELEMENT_SIZE_IN_BITS (EW),
            .NUMBER_SETS                 (NUMBER_SETS),
            .SET_PTR_WIDTH_IN_BITS       (SET_PTR_WIDTH_IN_BITS),
            .WRITE_FIRST                 (WRITE_FIRST)
        ) u_way (
            .clk_in        (clk_in),
            .en            (sweeping | accept),
            .we            (sweeping | (accept & write_en_in[w])),
            .byte_en       (sweeping ? '1 : byte_en_in),
            .set_addr      (sweeping ? count_q : access_set_addr_in),
            .write_element (sweeping ? INIT_VALUE : write_element_in[w*EW +: EW]),
            .read_element  (rd_raw[w*EW +: EW])
        );
    end

`ifdef BLOCKRAM_OUTPUT_REG_EN
    logic [DW-1:0] stage_data;
    logic          stage_valid;

    // Two-deep output pipe; each stage only reloads when it carries a new read.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            stage_data       <= '0;
            stage_valid      <= 1'b0;
            read_element_out <= '0;
            read_valid_out   <= 1'b0;
        end else begin
            stage_valid    <= accept;
            read_valid_out <= stage_valid;
            if (accept) begin
                stage_data <= rd_raw;
            end
            if (stage_valid) begin
                read_element_out <= stage_data;
            end
        end
    end
`else
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            read_element_out <= '0;
            read_valid_out   <= 1'b0;
        end else begin
            read_valid_out <= accept;
            if (accept) begin
                read_element_out <= rd_raw;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multi_way_init_blockram.sv
// Scoreboard bench driving a read-first and a write-first instance in lockstep
// against an array model of the sets and ways.
module tb_multi_way_init_blockram;

    localparam int EW   = 32;
    localparam int SETS = 64;
    localparam int WAYS = 4;
    localparam int DW   = EW * WAYS;
    localparam logic [EW-1:0] INITV = 32'hC0FFEE11;
`ifdef BLOCKRAM_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [DW-1:0] rf;
        logic [DW-1:0] wf;
        int            cyc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          init_req;
    logic          access_en;
    logic [3:0]    we;
    logic [3:0]    be;
    logic [5:0]    addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd_rf, rd_wf;
    logic          valid_rf, valid_wf, ready_rf, ready_wf;

    exp_t          sb[$];
    logic [EW-1:0] model [WAYS][SETS];
    logic [DW-1:0] last_rf, last_wf;
    logic          tb_ready;
    int            cyc;
    int            n_cmp;
    int            n_fail;

    multi_way_init_blockram #(
        .SINGLE_ELEMENT_SIZE_IN_BITS (EW), .NUMBER_SETS (SETS), .SET_PTR_WIDTH_IN_BITS (6),
        .NUMBER_WAYS (WAYS), .WRITE_FIRST (0), .INIT_VALUE (INITV)
    ) dut_rf (
        .clk_in (clk), .reset_in (rst_n), .init_req_in (init_req), .access_en_in (access_en),
        .write_en_in (we), .byte_en_in (be), .access_set_addr_in (addr),
        .write_element_in (wdata), .read_element_out (rd_rf),
        .read_valid_out (valid_rf), .ready_out (ready_rf)
    );

    multi_way_init_blockram #(
        .SINGLE_ELEMENT_SIZE_IN_BITS (EW), .NUMBER_SETS (SETS), .SET_PTR_WIDTH_IN_BITS (6),
        .NUMBER_WAYS (WAYS), .WRITE_FIRST (1), .INIT_VALUE (INITV)
    ) dut_wf (
        .clk_in (clk), .reset_in (rst_n), .init_req_in (init_req), .access_en_in (access_en),
        .write_en_in (we), .byte_en_in (be), .access_set_addr_in (addr),
        .write_element_in (wdata), .read_element_out (rd_wf),
        .read_valid_out (valid_wf), .ready_out (ready_wf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clearModel();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++)
                model[w][s] = INITV;
    endtask

    // Drive one cycle of inputs; if the model says it will be accepted, predict the read.
    task automatic applyStimulus(input logic acc, input logic [3:0] wen, input logic [3:0] ben,
                                 input logic [5:0] a, input logic [DW-1:0] data, input logic ireq);
        exp_t          e;
        logic [EW-1:0] old_v, new_v;
        @(posedge clk);
        #1;
        access_en = acc;
        we        = wen;
        be        = ben;
        addr      = a;
        wdata     = data;
        init_req  = ireq;
        if (tb_ready && acc && !ireq) begin
            for (int w = 0; w < WAYS; w++) begin
                old_v = model[w][a];
                new_v = old_v;
                for (int b = 0; b < 4; b++)
                    if (ben[b]) new_v[b*8 +: 8] = data[w*EW + b*8 +: 8];
                e.rf[w*EW +: EW] = old_v;
                if (wen[w]) begin
                    model[w][a]      = new_v;
                    e.wf[w*EW +: EW] = new_v;
                end else begin
                    e.wf[w*EW +: EW] = old_v;
                end
            end
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    // Watch ready through a sweep while throwing ignored accesses and init requests at it.
    task automatic waitSweep(input int low_cycles);
        for (int i = 1; i <= low_cycles + 1; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("ready_rf_c%0d", i), DW'(ready_rf), DW'(i == low_cycles + 1));
            checkOutput($sformatf("ready_wf_c%0d", i), DW'(ready_wf), DW'(i == low_cycles + 1));
            if (i <= low_cycles) begin
                access_en = 1'b1;
                we        = 4'($urandom);
                be        = 4'($urandom);
                addr      = 6'($urandom);
                wdata     = {$urandom, $urandom, $urandom, $urandom};
                init_req  = 1'($urandom_range(0, 1));
            end else begin
                access_en = 1'b0;
                init_req  = 1'b0;
                we        = '0;
            end
        end
    endtask

    function automatic logic [DW-1:0] randData();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: pops a prediction per valid pulse, otherwise checks that data holds.
    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("reset_rd_rf", rd_rf, '0);
            checkOutput("reset_rd_wf", rd_wf, '0);
            checkOutput("reset_valid", DW'({valid_rf, valid_wf}), '0);
            last_rf = '0;
            last_wf = '0;
            sb.delete();
        end else if (valid_rf || valid_wf) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_valid: got rf=%0b wf=%0b expected none at cycle %0d",
                         valid_rf, valid_wf, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("latency", DW'(cyc), DW'(e.cyc + LAT));
                checkOutput("valid_rf", DW'(valid_rf), DW'(1));
                checkOutput("valid_wf", DW'(valid_wf), DW'(1));
                checkOutput("read_rf", rd_rf, e.rf);
                checkOutput("read_wf", rd_wf, e.wf);
                last_rf = e.rf;
                last_wf = e.wf;
            end
        end else begin
            if (sb.size() > 0 && cyc >= sb[0].cyc + LAT) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL missing_valid: got none expected pulse for issue cycle %0d at cycle %0d",
                         sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            checkOutput("hold_rf", rd_rf, last_rf);
            checkOutput("hold_wf", rd_wf, last_wf);
        end
    end

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        tb_ready  = 1'b0;
        last_rf   = '0;
        last_wf   = '0;
        rst_n     = 1'b0;
        init_req  = 1'b0;
        access_en = 1'b0;
        we        = '0;
        be        = '0;
        addr      = '0;
        wdata     = '0;
        clearModel();

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitSweep(63);
        tb_ready = 1'b1;

        applyStimulus(1, 4'b0000, 4'($urandom), 6'd0,  randData(), 0);
        applyStimulus(1, 4'b0000, 4'($urandom), 6'd31, randData(), 0);
        applyStimulus(1, 4'b0000, 4'($urandom), 6'd63, randData(), 0);

        applyStimulus(1, 4'b0100, 4'b1111, 6'd5, {32'h0, 32'hAABBCCDD, 64'h0}, 0);
        applyStimulus(1, 4'b0100, 4'b0101, 6'd5, {32'h0, 32'h11223344, 64'h0}, 0);
        applyStimulus(1, 4'b0000, 4'b0000, 6'd5, randData(), 0);

        applyStimulus(1, 4'b0001, 4'b1111, 6'd9, {96'h0, 32'h0}, 0);
        applyStimulus(1, 4'b0001, 4'b1111, 6'd9, {96'h0, 32'h12345678}, 0);

        for (int i = 0; i < 10; i++)
            applyStimulus(1, 4'($urandom), 4'($urandom), 6'($urandom), randData(), 0);

        for (int i = 0; i < 200; i++)
            applyStimulus(1'($urandom_range(0, 4) != 0), 4'($urandom), 4'($urandom),
                          6'($urandom_range(0, 15)), randData(), 0);

        applyStimulus(1, 4'b1111, 4'b1111, 6'd5, randData(), 1);
        clearModel();
        tb_ready = 1'b0;
        waitSweep(64);
        tb_ready = 1'b1;
        for (int s = 0; s < SETS; s++)
            applyStimulus(1, 4'b0000, 4'($urandom), 6'(s), randData(), 0);

        for (int i = 0; i < 30; i++)
            applyStimulus(1, 4'($urandom), 4'($urandom), 6'($urandom), randData(), 0);
        applyStimulus(1, 4'b1111, 4'b1111, 6'd40, randData(), 1);
        clearModel();
        tb_ready = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            @(posedge clk);
            #1;
            access_en = 1'b0;
            init_req  = 1'b0;
        end
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_rd_rf", rd_rf, '0);
        checkOutput("async_rst_rd_wf", rd_wf, '0);
        checkOutput("async_rst_valid", DW'({valid_rf, valid_wf}), '0);
        checkOutput("async_rst_ready", DW'({ready_rf, ready_wf}), '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitSweep(63);
        tb_ready = 1'b1;
        for (int s = 0; s < SETS; s++)
            applyStimulus(1, 4'b0000, 4'b0000, 6'(s), randData(), 0);

        applyStimulus(0, 4'b0000, 4'b0000, 6'd0, '0, 0);
        repeat (LAT + 3) @(posedge clk);
        #1;
        checkOutput("drain_empty", DW'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
